pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the Counter and target width in bits.
REQ-002 SHALL have parameter DEPTHI, default 16, meaning instruction-memory byte address bits; the reachable space is 1<<DEPTHI bytes.
REQ-003 SHALL have parameter RESET_ADDR, default 0, meaning the first fetch address after reset.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port stall  input  1  hold Counter this cycle.
REQ-007 SHALL have port branch  input  1  redirect to branch_target.
REQ-008 SHALL have port branch_target  input  WIDTH  branch byte address.
REQ-009 SHALL have port jump  input  1  redirect to jump_target.
REQ-010 SHALL have port jump_target  input  WIDTH  jump byte address.
REQ-011 SHALL have port halt  input  1  stop fetching until reset.
REQ-012 SHALL have port Counter  output  WIDTH  byte fetch address, registered.
REQ-013 SHALL have port pc_valid  output  1  Counter holds a fetch to be consumed downstream.
REQ-014 SHALL have port flush  output  1  discard downstream fetch-pipeline contents.
REQ-015 SHALL have port pc_plus4  output  WIDTH  combinational Counter+4, masked per REQ-021, link value.
REQ-016 SHALL have port misalign  output  1  one-cycle pulse, only present behaviourally under REQ-030.

Function
REQ-017 SHALL implement FSM states BOOT, RUN, STALL, HALT; reset enters BOOT.
REQ-018 SHALL move BOOT->RUN after exactly one cycle, Counter=RESET_ADDR, pc_valid=0 in BOOT, pc_valid=1 on entering RUN.
REQ-019 SHALL evaluate each edge in priority halt > jump > branch > stall > increment.
REQ-020 SHALL, in RUN with no event, set Counter <= Counter+4.
REQ-021 SHALL mask Counter to DEPTHI bits with bits[1:0]=0; increment from (1<<DEPTHI)-4 SHALL wrap to 0.
REQ-022 SHALL, on stall with no redirect, enter/remain in STALL, hold Counter, and hold pc_valid at 1.
REQ-023 SHALL, on jump or branch in RUN or STALL, load the masked target next edge, return to RUN, and assert flush for exactly 2 cycles starting the cycle after the edge (covers the two-stage instruction-register latency).
REQ-024 SHALL deassert pc_valid during flush cycles and reassert it when flush ends.
REQ-025 SHALL treat a redirect arriving during an active flush as a new redirect, restarting the 2-cycle flush count.
REQ-026 SHALL, on halt, enter HALT next edge, freeze Counter, drive pc_valid=0, flush=0; HALT is left only by reset.
REQ-027 SHALL ignore all inputs in BOOT.

Reset
REQ-028 SHALL, while rst=0, asynchronously force Counter=RESET_ADDR masked, pc_valid=0, flush=0, misalign=0, flush count=0, state=BOOT.
REQ-029 SHALL, on reset mid-flush or mid-stall, abandon that operation entirely; deassertion is sampled on the next clk edge.

Configuration
REQ-030 SHALL, with macro PC_ALIGN_CHECK_EN defined, pulse misalign for one cycle and enter HALT instead of redirecting when the selected target has bits[1:0]!=0.
REQ-031 SHALL, without PC_ALIGN_CHECK_EN, silently clear target bits[1:0], tie misalign to 0, and never enter HALT from a target.

Structure
REQ-032 SHALL place the FSM state enum, the flush length constant (2), and the instruction size constant (4) in shared package fetch_pkg.
REQ-033 SHALL be a single module with no sub-modules; fetch_pkg is imported.

Verification
REQ-034 SHALL cover: reset release -> one BOOT cycle with Counter=0, pc_valid=0, then Counter sequence 0, 4, 8, 12.
REQ-035 SHALL cover: stall held 3 cycles at Counter=0x10 -> Counter stays 0x10 for 3 cycles, then 0x14.
REQ-036 SHALL cover: branch and jump asserted together, jump_target=0x40, branch_target=0x80 -> Counter=0x40, flush high 2 cycles, pc_valid low for those 2 cycles.
REQ-037 SHALL cover: DEPTHI=8, Counter=0xFC, increment -> Counter=0x00.
REQ-038 SHALL cover: PC_ALIGN_CHECK_EN defined, jump_target=0x42 -> misalign pulse, HALT, Counter frozen; macro undefined -> Counter=0x40.
REQ-039 SHALL cover: rst driven low mid-flush, between clock edges -> outputs reach reset values immediately without waiting for an edge; BOOT follows rst release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-unit definitions: FSM state encoding, flush length and instruction size.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam int unsigned FLUSH_LEN  = 2;
    localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: boot, sequential increment, stall, jump/branch redirect with flush, halt.
// Optional target alignment trap enabled by defining PC_ALIGN_CHECK_EN.
//
// state | meaning
// BOOT  | one cycle after reset, Counter=RESET_ADDR, inputs ignored
// RUN   | fetching, Counter advances by 4 unless flushing
// STALL | Counter held, pc_valid held
// HALT  | Counter frozen, pc_valid=0, left only by reset
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              WIDTH      = 32,
    parameter int              DEPTHI     = 16,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             halt,
    output logic [WIDTH-1:0] Counter,
    output logic             pc_valid,
    output logic             flush,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             misalign
);

    localparam logic [1:0] S_BOOT  = BOOT;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_STALL = STALL;
    localparam logic [1:0] S_HALT  = HALT;

    localparam int FC_W = $clog2(FLUSH_LEN + 1);

    function automatic logic [WIDTH-1:0] calc_mask();
        logic [WIDTH-1:0] m;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = (i >= 2) && (i < DEPTHI);
        end
        return m;
    endfunction

    localparam logic [WIDTH-1:0] ADDR_MASK = calc_mask();

    logic [1:0]       state;
    logic [FC_W-1:0]  flush_cnt;
    logic             redirect;
    logic [WIDTH-1:0] sel_target;
    logic [WIDTH-1:0] masked_target;

    assign redirect      = jump | branch;
    assign sel_target    = jump ? jump_target : branch_target;
    assign masked_target = sel_target & ADDR_MASK;
    assign pc_plus4      = (Counter + WIDTH'(INSN_BYTES)) & ADDR_MASK;
    assign flush         = (flush_cnt != '0);
    assign pc_valid      = ((state == S_RUN) || (state == S_STALL)) && (flush_cnt == '0);

`ifdef PC_ALIGN_CHECK_EN
    logic target_misaligned;
    logic misalign_q;

    assign target_misaligned = (sel_target[1:0] != 2'b00);
    assign misalign          = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    // Counter is held while flushing so the redirect target is the first
    // address presented with pc_valid once the flush window closes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_BOOT;
            Counter   <= RESET_ADDR & ADDR_MASK;
            flush_cnt <= '0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
            case (state)
                S_BOOT: state <= S_RUN;
                S_RUN, S_STALL: begin
                    if (halt) begin
                        state     <= S_HALT;
                        flush_cnt <= '0;
                    end else if (redirect) begin
`ifdef PC_ALIGN_CHECK_EN
                        if (target_misaligned) begin
                            state      <= S_HALT;
                            flush_cnt  <= '0;
                            misalign_q <= 1'b1;
                        end else
`endif
                        begin
                            Counter   <= masked_target;
                            state     <= S_RUN;
                            flush_cnt <= FC_W'(FLUSH_LEN);
                        end
                    end else begin
                        if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
                        if (stall) begin
                            state <= S_STALL;
                        end else begin
                            state <= S_RUN;
                            if (flush_cnt == '0) Counter <= pc_plus4;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
